// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the register file's single write port among
// N_REQ writeback requesters, with a registered write stage and grant bookkeeping.
module regfile_write_arbiter #(
    parameter int WORD_WIDTH = 32,
    parameter int N_REQ      = 3,
    localparam int GW        = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hold,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [5*N_REQ-1:0]          req_addr,
    input  logic [WORD_WIDTH*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic [4:0]                  regWriteAddr,
    output logic [WORD_WIDTH-1:0]       dataToWrite,
    output logic                        toWrite,
    output logic [GW-1:0]               last_grant,
    output logic [15:0]                 grant_count
);

    logic [GW-1:0]         ptr;
    logic [N_REQ-1:0]      upper_mask;
    logic [N_REQ-1:0]      upper_req;
    logic [N_REQ-1:0]      pick;
    logic [N_REQ-1:0]      grant;
    logic                  found;
    logic [GW-1:0]         win_idx;
    logic [4:0]            win_addr;
    logic [WORD_WIDTH-1:0] win_data;
    logic                  accept;

    // Requesters at or above ptr take precedence; if none is valid, the scan
    // wraps to the lowest valid index below ptr.
    always_comb begin
        upper_mask = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            upper_mask[i] = (i >= 32'(ptr));
        end
        upper_req = req_valid & upper_mask;
        pick      = (upper_req != '0) ? upper_req : req_valid;

        grant   = '0;
        found   = 1'b0;
        win_idx = '0;
        if (!hold) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (pick[i] && !found) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    win_idx  = GW'(i);
                end
            end
        end
    end

    // Data path select keyed only by the one-hot grant, so ready never depends on addr/data.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                win_addr = req_addr[5*i +: 5];
                win_data = req_data[WORD_WIDTH*i +: WORD_WIDTH];
            end
        end
    end

    always_comb begin
        req_ready = rst ? '0 : grant;
        accept    = |req_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr          <= '0;
            regWriteAddr <= '0;
            dataToWrite  <= '0;
            toWrite      <= 1'b0;
            last_grant   <= '0;
            grant_count  <= '0;
        end else begin
            toWrite <= 1'b0;
            if (accept) begin
                regWriteAddr <= win_addr;
                dataToWrite  <= win_data;
                toWrite      <= (win_addr != 5'd0);
                last_grant   <= win_idx;
                ptr          <= (win_idx == GW'(N_REQ - 1)) ? '0 : win_idx + GW'(1);
                grant_count  <= grant_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: stimulus queues expected writes,
// a negedge monitor pops and compares each issued register write.
module tb_regfile_write_arbiter;

    localparam int W  = 32;
    localparam int N  = 3;
    localparam int GW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             hold;
    logic [N-1:0]     req_valid;
    logic [5*N-1:0]   req_addr;
    logic [W*N-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic [4:0]       regWriteAddr;
    logic [W-1:0]     dataToWrite;
    logic             toWrite;
    logic [GW-1:0]    last_grant;
    logic [15:0]      grant_count;

    regfile_write_arbiter #(.WORD_WIDTH(W), .N_REQ(N)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .regWriteAddr(regWriteAddr),
        .dataToWrite(dataToWrite), .toWrite(toWrite),
        .last_grant(last_grant), .grant_count(grant_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  lg;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] regmodel [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
        req_valid[i]       = v;
        req_addr[5*i +: 5] = a;
        req_data[W*i +: W] = d;
    endtask

    task automatic expect_write(input logic [4:0] a, input logic [31:0] d,
                                input logic [1:0] lg, input logic [15:0] cnt);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.lg   = lg;
        e.cnt  = cnt;
        e.cyc  = cyc + 1;
        sb.push_back(e);
    endtask

    // Monitor: every issued write must match the oldest expectation, one cycle after acceptance.
    always @(negedge clk) begin
        if (!rst && toWrite) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         regWriteAddr, dataToWrite);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_addr",  {27'b0, regWriteAddr}, {27'b0, e.addr});
                check("wr_data",  dataToWrite, e.data);
                check("wr_grant", {30'b0, last_grant}, {30'b0, e.lg});
                check("wr_count", {16'b0, grant_count}, {16'b0, e.cnt});
                check("wr_cycle", cyc, e.cyc);
            end
            regmodel[regWriteAddr] = dataToWrite;
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] rr_exp [6];
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        for (int r = 0; r < 32; r++) regmodel[r] = '0;
        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;

        // Reset state, with requests present
        next_cycle();
        req_valid = '1;
        #1;
        check("rdy_in_reset", {29'b0, req_ready}, 32'h0);
        check("rst_towrite",  {31'b0, toWrite}, 32'h0);
        check("rst_addr",     {27'b0, regWriteAddr}, 32'h0);
        check("rst_data",     dataToWrite, 32'h0);
        check("rst_grant",    {30'b0, last_grant}, 32'h0);
        check("rst_count",    {16'b0, grant_count}, 32'h0);
        req_valid = '0;

        // Round-robin fairness from reset
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 32'h100 + 32'(i));
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("rdy_rr%0d", k), {29'b0, req_ready}, {29'b0, rr_exp[k]});
            expect_write(5'(k % 3 + 1), 32'h100 + 32'(k % 3), 2'(k % 3), 16'(k + 1));
            next_cycle();
        end
        req_valid = '0;
        #1;
        check("rr_count", {16'b0, grant_count}, 32'd6);

        // Single requester: ptr is back at 0, requester 1 alone
        next_cycle();
        set_req(1, 1'b1, 5'd8, 32'hDEADBEEF);
        #1;
        check("rdy_single", {29'b0, req_ready}, 32'b010);
        expect_write(5'd8, 32'hDEADBEEF, 2'd1, 16'd7);
        next_cycle();
        req_valid = '0;
        #1;
        check("single_towrite", {31'b0, toWrite}, 32'h1);
        check("single_addr",    {27'b0, regWriteAddr}, 32'd8);

        // Address 0: ptr is 2, requester 2 writes r0
        next_cycle();
        set_req(2, 1'b1, 5'd0, 32'h1234);
        #1;
        check("rdy_addr0", {29'b0, req_ready}, 32'b100);
        next_cycle();
        hold = 1'b1;
        set_req(0, 1'b1, 5'd1, 32'h100);
        set_req(1, 1'b1, 5'd2, 32'h101);
        set_req(2, 1'b1, 5'd3, 32'h102);
        #1;
        check("addr0_towrite", {31'b0, toWrite}, 32'h0);
        check("addr0_grant",   {30'b0, last_grant}, 32'd2);
        check("addr0_count",   {16'b0, grant_count}, 32'd8);
        check("rdy_hold0",     {29'b0, req_ready}, 32'h0);

        // Hold for two more cycles, then the grant goes to the pre-hold ptr (0)
        for (int k = 1; k < 3; k++) begin
            next_cycle();
            #1;
            check($sformatf("rdy_hold%0d", k), {29'b0, req_ready}, 32'h0);
            check($sformatf("hold_towrite%0d", k), {31'b0, toWrite}, 32'h0);
            check($sformatf("hold_count%0d", k), {16'b0, grant_count}, 32'd8);
        end
        next_cycle();
        hold = 1'b0;
        #1;
        check("rdy_after_hold", {29'b0, req_ready}, 32'b001);
        expect_write(5'd1, 32'h100, 2'd0, 16'd9);
        next_cycle();
        req_valid = '0;

        // Reset mid-operation: ptr is 1, requester 0 accepted, reset before its write edge
        next_cycle();
        set_req(0, 1'b1, 5'd5, 32'h55);
        #1;
        check("rdy_midop", {29'b0, req_ready}, 32'b001);
        next_cycle();
        req_valid = '0;
        rst = 1'b1;
        #1;
        check("midop_towrite", {31'b0, toWrite}, 32'h0);
        check("midop_addr",    {27'b0, regWriteAddr}, 32'h0);
        check("midop_data",    dataToWrite, 32'h0);
        check("midop_grant",   {30'b0, last_grant}, 32'h0);
        check("midop_count",   {16'b0, grant_count}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        check("midop_reg5", regmodel[5], 32'h0);

        // Same-address conflict: ptr reset to 0 so requester 0 wins first
        set_req(0, 1'b1, 5'd9, 32'h11);
        set_req(1, 1'b1, 5'd9, 32'h22);
        #1;
        check("rdy_conf0", {29'b0, req_ready}, 32'b001);
        expect_write(5'd9, 32'h11, 2'd0, 16'd1);
        next_cycle();
        req_valid[0] = 1'b0;
        #1;
        check("rdy_conf1", {29'b0, req_ready}, 32'b010);
        expect_write(5'd9, 32'h22, 2'd1, 16'd2);
        next_cycle();
        req_valid = '0;
        #1;
        check("conf_count", {16'b0, grant_count}, 32'd2);
        @(negedge clk);
        #1;
        check("conf_reg9", regmodel[9], 32'h22);

        repeat (3) next_cycle();
        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
